// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative RV32M multiply/divide unit for the EX stage. It takes one
//   operation at a time. A multiply is a 32-step shift-add over the operand
//   magnitudes. A divide is a 32-step restoring divide. Results are
//   sign-corrected at the end of the run.
//
// Ports
//   clk_i      in   1   clock, rising edge
//   rst_n_i    in   1   asynchronous active-low reset
//   start_i    in   1   operation request, sampled only while ready_o=1
//   op_i       in   3   funct3: mul mulh mulhsu mulhu div divu rem remu
//   rs1_i      in   32  operand a (multiplicand / dividend)
//   rs2_i      in   32  operand b (multiplier / divisor)
//   kill_i     in   1   abandon current or just-requested operation
//   ready_o    out  1   idle, can accept start_i
//   busy_o     out  1   pipeline stall while an operation is in flight
//   valid_o    out  1   one-cycle result strobe
//   result_o   out  32  result, held until the next completion
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | one multiply/divide iteration per cycle, counter 0..31
// DONE  | valid_o high for this single cycle
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;

    // Operand decode for a new request
    logic            a_signed;
    logic            b_signed;
    logic            sign_a;
    logic            sign_b;
    logic            neg_start;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed    = 1'b0;
        b_signed    = 1'b0;
        special     = 1'b0;
        special_res = '0;
        if (op_i[2]) begin
            a_signed = ~op_i[0];
            b_signed = ~op_i[0];
        end else begin
            a_signed = (op_i[1:0] != 2'b11);
            b_signed = ~op_i[1];
        end
        sign_a = a_signed & rs1_i[XLEN-1];
        sign_b = b_signed & rs2_i[XLEN-1];
        // rem/remu take the dividend's sign; everything else takes a^b
        neg_start = (op_i[2] & op_i[1]) ? sign_a : (sign_a ^ sign_b);
        mag_a = sign_a ? (~rs1_i + 1'b1) : rs1_i;
        mag_b = sign_b ? (~rs2_i + 1'b1) : rs2_i;

        if (op_i[2]) begin
            if (rs2_i == '0) begin
                special     = 1'b1;
                special_res = op_i[1] ? rs1_i : '1;
            end else if (!op_i[0] && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_i == '1) begin
                special     = 1'b1;
                special_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end
    end

    // One multiply step: add a to the upper half when the current multiplier
    // bit is set, then shift the whole product right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    // One divide step: acc_q holds {remainder, quotient}. The borrow out of
    // the trial subtraction decides the quotient bit.
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_q[cnt_q] ? a_q : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // dividend bits are consumed MSB first; ~cnt_q equals XLEN-1-cnt_q
        div_trial = {acc_q[2*XLEN-1:XLEN], a_q[~cnt_q]};
        div_diff  = div_trial - {1'b0, b_q};
        div_ge    = ~div_diff[XLEN];
        div_rem   = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
    end

    // Final selection with sign correction, used on the last CALC edge
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_fix = neg_q ? (~mul_next + 1'b1) : mul_next;
        quo_fix  = neg_q ? (~div_next[XLEN-1:0] + 1'b1) : div_next[XLEN-1:0];
        rem_fix  = neg_q ? (~div_next[2*XLEN-1:XLEN] + 1'b1) : div_next[2*XLEN-1:XLEN];
        final_res = '0;
        case (op_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else if (kill_i) begin
            state_q <= IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_o <= 1'b0;
                    if (start_i) begin
                        op_q  <= op_i;
                        a_q   <= mag_a;
                        b_q   <= mag_b;
                        neg_q <= neg_start;
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (special) begin
                            result_o <= special_res;
                            valid_o  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        result_o <= final_res;
                        valid_o  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    valid_o <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_o <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latency,
// stall window, kill and asynchronous reset behaviour.
module tb_muldiv_sequencer;

    logic        clk_i;
    logic        rst_n_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        kill_i;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    muldiv_sequencer dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally hold start_i high (with a different rs1) for
    // `hold` cycles after acceptance, then check latency, stall and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        int busy_cnt;
        lat      = -1;
        busy_cnt = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        @(posedge clk_i);
        #1;
        if (hold == 0) start_i = 1'b0;
        else rs1_i = ~a;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk_i);
            if (busy_o) busy_cnt++;
            if (k + 1 >= hold) start_i = 1'b0;
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        start_i = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result_o, exp);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
        @(negedge clk_i);
        check({tag, " ready after"}, {31'b0, ready_o}, 32'd1);
        check({tag, " valid one cycle"}, {31'b0, valid_o}, 32'd0);
        check({tag, " result held"}, result_o, exp);
    endtask

    initial begin
        rst_n_i = 1'b0;
        start_i = 1'b0;
        op_i    = 3'b000;
        rs1_i   = 32'd0;
        rs2_i   = 32'd0;
        kill_i  = 1'b0;
        #12;
        check("reset ready", {31'b0, ready_o}, 32'd1);
        check("reset busy", {31'b0, busy_o}, 32'd0);
        check("reset valid", {31'b0, valid_o}, 32'd0);
        check("reset result", result_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        run_op("mul 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32, 0);
        run_op("mulh min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32, 0);
        run_op("mulhu ffff^2",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 0);
        run_op("mulhsu -1*ffff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 0);
        run_op("div -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32, 0);
        run_op("rem -7%2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32, 0);
        run_op("divu 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       32, 0);
        run_op("remu 100%7",      3'b111, 32'd100,      32'd7,        32'd2,        32, 0);

        // kill on the 10th CALC cycle of a mul 5*6; prior result is 2
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 3'b000;
        rs1_i   = 32'd5;
        rs2_i   = 32'd6;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        check("kill busy before", {31'b0, busy_o}, 32'd1);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1 kill_i = 1'b0;
        @(negedge clk_i);
        check("kill ready", {31'b0, ready_o}, 32'd1);
        check("kill valid", {31'b0, valid_o}, 32'd0);
        check("kill result kept", result_o, 32'd2);
        begin
            int vcnt;
            vcnt = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk_i);
                if (valid_o) vcnt++;
            end
            check("kill no valid", 32'(vcnt), 32'd0);
        end

        // kill beats start in the same cycle
        @(negedge clk_i);
        start_i = 1'b1;
        kill_i  = 1'b1;
        op_i    = 3'b101;
        rs1_i   = 32'd8;
        rs2_i   = 32'd0;
        @(posedge clk_i);
        #1 begin start_i = 1'b0; kill_i = 1'b0; end
        @(negedge clk_i);
        check("kill over start ready", {31'b0, ready_o}, 32'd1);
        check("kill over start valid", {31'b0, valid_o}, 32'd0);

        run_op("divu 9/3 held",   3'b101, 32'd9,        32'd3,        32'd3,        32, 5);

        run_op("div 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0);
        run_op("rem 5%0",         3'b110, 32'd5,        32'd0,        32'd5,        0, 0);
        run_op("div ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        run_op("rem ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 0);

        // asynchronous reset in the middle of a CALC clock period
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 3'b000;
        rs1_i   = 32'd9;
        rs2_i   = 32'd9;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        check("async rst ready", {31'b0, ready_o}, 32'd1);
        check("async rst busy", {31'b0, busy_o}, 32'd0);
        check("async rst valid", {31'b0, valid_o}, 32'd0);
        check("async rst result", result_o, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        run_op("mul 3*4",         3'b000, 32'd3,        32'd4,        32'd12,       32, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
